// File: rtl/boot_pkg.sv
// Shared boot sequencing constants: state encoding, NOP word and the
// opcode field used by both the sequencer and the CPU decoder.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_BIOS_RUN = 3'd1,
    ST_HANDOFF  = 3'd2,
    ST_USER_RUN = 3'd3,
    ST_FAULT    = 3'd4
  } boot_state_e;

  localparam logic [31:0] NOP_WORD   = 32'h6C00_0000;
  localparam logic [5:0]  END_OPCODE = 6'b100111;
  localparam int          OPC_MSB    = 31;
  localparam int          OPC_LSB    = 26;

  function automatic logic [5:0] opcode_of(input logic [31:0] w);
    return w[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/boot_watchdog.sv
// BIOS run-time watchdog: counts BIOS_RUN cycles, flags the LIMIT-th one.
// Ports: clock, reset (async high), run (in BIOS_RUN), hit (limit cycle).
module boot_watchdog #(
  parameter int LIMIT = 1023
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic hit
);

  logic [9:0] count_q;
  logic [9:0] count_d;

  // count_q holds completed BIOS_RUN cycles, so the current one is
  // number count_q+1; leaving BIOS_RUN clears it for the next entry.
  always_comb begin
    count_d = '0;
    if (run && count_q != '1)
      count_d = count_q + 10'd1;
    else if (run)
      count_d = count_q;
  end

  assign hit = run && (count_q == 10'(LIMIT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: runs the BIOS ROM, hands the CPU over to user memory.
// Ports: clock, reset (async high), pc, bios_data, imem_data in;
// bios_address, imem_address, instruction, cpu_stall, pc_reset,
// boot_done, boot_error out. Optional watchdog: BOOT_WATCHDOG_EN.
module boot_sequencer #(
  parameter int          ADDR_W         = 10,
  parameter int          DATA_W         = 32,
  parameter int          BIOS_DEPTH     = 29,
  parameter logic [5:0]  END_OPCODE     = boot_pkg::END_OPCODE,
  parameter int          HANDOFF_CYCLES = 2,
  parameter int          WDOG_LIMIT     = 1023
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] bios_data,
  input  logic [DATA_W-1:0] imem_data,
  output logic [ADDR_W-1:0] bios_address,
  output logic [ADDR_W-1:0] imem_address,
  output logic [DATA_W-1:0] instruction,
  output logic              cpu_stall,
  output logic              pc_reset,
  output logic              boot_done,
  output logic              boot_error
);

  import boot_pkg::*;

  localparam int CNT_W = $clog2(HANDOFF_CYCLES + 1);

  boot_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pc_oob;
  logic end_mark;
  logic wdog_hit;

  assign pc_oob   = {1'b0, pc} >= (ADDR_W+1)'(BIOS_DEPTH);
  assign end_mark = opcode_of(bios_data[31:0]) == END_OPCODE;

`ifdef BOOT_WATCHDOG_EN
  boot_watchdog #(
    .LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clock (clock),
    .reset (reset),
    .run   (state_q == ST_BIOS_RUN),
    .hit   (wdog_hit)
  );
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    instruction  = DATA_W'(NOP_WORD);
    cpu_stall    = 1'b1;
    pc_reset     = 1'b0;
    boot_done    = 1'b0;
    boot_error   = 1'b0;
    bios_address = '0;
    imem_address = '0;
    unique case (state_q)
      ST_INIT: begin
        state_d = ST_BIOS_RUN;
      end
      ST_BIOS_RUN: begin
        cpu_stall    = 1'b0;
        bios_address = pc;
        // Range fault beats the end marker; the marker word itself
        // is replaced by a NOP so it never reaches decode.
        if (pc_oob) begin
          state_d = ST_FAULT;
        end else if (end_mark) begin
          state_d = ST_HANDOFF;
          cnt_d   = CNT_W'(HANDOFF_CYCLES - 1);
        end else begin
          instruction = bios_data;
          if (wdog_hit)
            state_d = ST_FAULT;
        end
      end
      ST_HANDOFF: begin
        if (cnt_q == '0) begin
          pc_reset = 1'b1;
          state_d  = ST_USER_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_USER_RUN: begin
        cpu_stall    = 1'b0;
        boot_done    = 1'b1;
        imem_address = pc;
        instruction  = imem_data;
      end
      ST_FAULT: begin
        boot_error = 1'b1;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Scoreboard bench for boot_sequencer: driver queues per-cycle
// expectations, monitor pops and compares on the falling edge.
module tb_boot_sequencer;

  localparam logic [31:0] NOP = 32'h6C00_0000;
  localparam logic [31:0] MRK = 32'h9C00_0000;

  localparam int K_IDLE = 0;
  localparam int K_BIOS = 1;
  localparam int K_BNOP = 2;
  localparam int K_HO   = 3;
  localparam int K_HOL  = 4;
  localparam int K_USER = 5;
  localparam int K_FLT  = 6;

  logic        clock;
  logic        reset;
  logic [9:0]  pc;
  logic [31:0] bios_data;
  logic [31:0] imem_data;
  logic [9:0]  bios_address;
  logic [9:0]  imem_address;
  logic [31:0] instruction;
  logic        cpu_stall;
  logic        pc_reset;
  logic        boot_done;
  logic        boot_error;

  typedef struct {
    string       nm;
    logic [31:0] ins;
    logic        st;
    logic        pr;
    logic        dn;
    logic        er;
    logic [9:0]  ba;
    logic [9:0]  ia;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  boot_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .pc           (pc),
    .bios_data    (bios_data),
    .imem_data    (imem_data),
    .bios_address (bios_address),
    .imem_address (imem_address),
    .instruction  (instruction),
    .cpu_stall    (cpu_stall),
    .pc_reset     (pc_reset),
    .boot_done    (boot_done),
    .boot_error   (boot_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc(input string nm, input logic r, input int k,
                     input logic [9:0] p, input logic [31:0] bd,
                     input logic [31:0] id);
    exp_t e;
    @(posedge clock);
    #1;
    reset     = r;
    pc        = p;
    bios_data = bd;
    imem_data = id;
    e.nm  = nm;
    e.ins = NOP;
    e.st  = 1'b1;
    e.pr  = 1'b0;
    e.dn  = 1'b0;
    e.er  = 1'b0;
    e.ba  = '0;
    e.ia  = '0;
    case (k)
      K_BIOS: begin e.ins = bd; e.st = 1'b0; e.ba = p; end
      K_BNOP: begin e.st = 1'b0; e.ba = p; end
      K_HOL:  e.pr = 1'b1;
      K_USER: begin
        e.ins = id; e.st = 1'b0; e.dn = 1'b1; e.ia = p;
      end
      K_FLT:  e.er = 1'b1;
      default: ;
    endcase
    q.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (instruction !== e.ins || cpu_stall !== e.st ||
          pc_reset !== e.pr || boot_done !== e.dn ||
          boot_error !== e.er || bios_address !== e.ba ||
          imem_address !== e.ia) begin
        failures++;
        $display("FAIL %s: got ins=%h st=%b pr=%b dn=%b er=%b ba=%0d ia=%0d exp ins=%h st=%b pr=%b dn=%b er=%b ba=%0d ia=%0d",
                 e.nm, instruction, cpu_stall, pc_reset, boot_done,
                 boot_error, bios_address, imem_address, e.ins, e.st,
                 e.pr, e.dn, e.er, e.ba, e.ia);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    pc        = '0;
    bios_data = '0;
    imem_data = '0;

    // Reset, INIT, BIOS walk to the end marker, handoff, user run.
    cyc("rst_a", 1'b1, K_IDLE, 10'd0, 32'h0, 32'h0);
    cyc("init_a", 1'b0, K_IDLE, 10'd0, 32'h0000_1000, 32'h0);
    for (int i = 0; i < 20; i++)
      cyc($sformatf("bios%0d", i), 1'b0, K_BIOS, 10'(i),
          32'h0000_1000 + i, 32'h5555_0000);
    cyc("marker20", 1'b0, K_BNOP, 10'd20, MRK, 32'h0);
    cyc("ho1", 1'b0, K_HO, 10'd21, 32'h0000_2000, 32'h1);
    cyc("ho2", 1'b0, K_HOL, 10'd21, 32'h0000_2000, 32'h2);
    cyc("user0", 1'b0, K_USER, 10'd0, 32'h0, 32'hAAAA_0001);
    cyc("user_mrk", 1'b0, K_USER, 10'd1, MRK, MRK);
    cyc("user2", 1'b0, K_USER, 10'd2, 32'h0, 32'h1234_5678);
    cyc("user_oob", 1'b0, K_USER, 10'd500, MRK, 32'hDEAD_BEEF);

    // Range fault, also with a marker present on the faulting word.
    cyc("rst_b", 1'b1, K_IDLE, 10'd0, 32'h0, 32'h0);
    cyc("init_b", 1'b0, K_IDLE, 10'd3, 32'h0, 32'h0);
    cyc("bios3", 1'b0, K_BIOS, 10'd3, 32'h0BAD_0003, 32'h0);
    cyc("bios28", 1'b0, K_BIOS, 10'd28, 32'h0000_001C, 32'h0);
    cyc("oob29", 1'b0, K_BNOP, 10'd29, MRK, 32'h0);
    cyc("flt1", 1'b0, K_FLT, 10'd0, 32'h1, 32'h1);
    cyc("flt2", 1'b0, K_FLT, 10'd5, MRK, 32'h2);
    cyc("flt3", 1'b0, K_FLT, 10'd1023, 32'h3, 32'h3);

    // Reset during the first handoff cycle suppresses pc_reset.
    cyc("rst_c", 1'b1, K_IDLE, 10'd0, 32'h0, 32'h0);
    cyc("init_c", 1'b0, K_IDLE, 10'd0, MRK, 32'h0);
    cyc("mrk0", 1'b0, K_BNOP, 10'd0, MRK, 32'h0);
    cyc("ho_abort", 1'b1, K_IDLE, 10'd1, 32'h7, 32'h7);
    cyc("init_c2", 1'b0, K_IDLE, 10'd0, 32'h7, 32'h7);
    cyc("bios_c0", 1'b0, K_BIOS, 10'd0, 32'h0000_0C00, 32'h7);
    cyc("bios_c1", 1'b0, K_BIOS, 10'd1, 32'h0000_0C01, 32'h7);

    // Long BIOS residency at one pc with no marker.
    cyc("rst_d", 1'b1, K_IDLE, 10'd0, 32'h0, 32'h0);
    cyc("init_d", 1'b0, K_IDLE, 10'd5, 32'h0000_0505, 32'h0);
    for (int i = 0; i < 2000; i++) begin
      int k;
`ifdef BOOT_WATCHDOG_EN
      k = (i < 1023) ? K_BIOS : K_FLT;
`else
      k = K_BIOS;
`endif
      cyc($sformatf("wd%0d", i), 1'b0, k, 10'd5, 32'h0000_0505, 32'h0);
    end

    @(negedge clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, exp 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
